// File: rtl/sprite_port_scheduler_pkg.sv
// Shared graphics types for the sprite port scheduler: screen/frame widths,
// scheduler state encoding, the sprite command word and the frame clamp helper.
package gfx_pkg;

  localparam int SCREEN_X_W  = 11;
  localparam int SCREEN_Y_W  = 10;
  localparam int FRAME_IDX_W = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    LATCH = 2'd2,
    HOLD  = 2'd3
  } sched_state_t;

  typedef struct packed {
    logic                   valid;
    logic [SCREEN_X_W-1:0]  x;
    logic [SCREEN_Y_W-1:0]  y;
    logic [FRAME_IDX_W-1:0] frame;
  } sprite_cmd_t;

  // Sum is formed one bit wider so a sheet overrun clamps instead of wrapping.
  function automatic logic [FRAME_IDX_W-1:0] clamp_frame(
    input logic [FRAME_IDX_W-1:0] base,
    input logic [FRAME_IDX_W-1:0] phase,
    input logic [FRAME_IDX_W:0]   max_idx
  );
    logic [FRAME_IDX_W:0] sum;
    sum = {1'b0, base} + {1'b0, phase};
    if (sum > max_idx) sum = max_idx;
    return sum[FRAME_IDX_W-1:0];
  endfunction

endpackage

// File: rtl/sprite_port_scheduler_if.sv
// Requester / graphics-side bundle of the sprite port scheduler.
// master = game logic + graphics consumer, slave = scheduler.
interface sprite_port_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import gfx_pkg::*;

  logic                                     new_frame;
  logic [NUM_REQ-1:0]                       req_valid;
  logic [NUM_REQ-1:0][SCREEN_X_W-1:0]       req_x;
  logic [NUM_REQ-1:0][SCREEN_Y_W-1:0]       req_y;
  logic [NUM_REQ-1:0][FRAME_IDX_W-1:0]      req_frame_base;
  logic [NUM_REQ-1:0][FRAME_IDX_W-1:0]      req_frame_len;
  logic [NUM_REQ-1:0]                       req_ack;
  logic                                     sprite_valid;
  logic [SCREEN_X_W-1:0]                    sprite_x;
  logic [SCREEN_Y_W-1:0]                    sprite_y;
  logic [FRAME_IDX_W-1:0]                   sprite_frame_number;
  logic                                     busy;

  modport master (
    output new_frame, req_valid, req_x, req_y, req_frame_base, req_frame_len,
    input  req_ack, sprite_valid, sprite_x, sprite_y, sprite_frame_number, busy
  );

  modport slave (
    input  new_frame, req_valid, req_x, req_y, req_frame_base, req_frame_len,
    output req_ack, sprite_valid, sprite_x, sprite_y, sprite_frame_number, busy
  );

endinterface

// File: rtl/sprite_port_scheduler_anim_phase_counter.sv
// Per-requester animation phase: advances on step, wraps at eff_len-1, and
// collapses to 0 when a shortened length leaves it out of range.
module anim_phase_counter
  import gfx_pkg::*;
(
  input  logic                   clk_pixel,
  input  logic                   sys_rst_n,
  input  logic                   step,
  input  logic [FRAME_IDX_W-1:0] eff_len,
  output logic [FRAME_IDX_W-1:0] phase
);

  logic [FRAME_IDX_W-1:0] phase_q, phase_d;

  always_comb begin
    phase_d = phase_q;
    if (step) begin
      if (phase_q >= eff_len - 1'b1) phase_d = '0;
      else                           phase_d = phase_q + 1'b1;
    end
  end

  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) phase_q <= '0;
    else            phase_q <= phase_d;
  end

  assign phase = phase_q;

endmodule

// File: rtl/sprite_port_scheduler.sv
// Round-robin, one-grant-per-video-frame sharing of the sprite port.
// Optional statistics outputs when SPRITE_SCHED_STATS_EN is defined.
//
//  state | meaning
//  IDLE  | after reset, waiting for the first new_frame
//  SCAN  | examining one requester per cycle from last_grant+1
//  LATCH | capturing granted requester into the sprite outputs
//  HOLD  | outputs stable until the next new_frame
module sprite_port_scheduler
  import gfx_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int NUM_FRAMES = 23,
  parameter int ANIM_DIV   = 4
) (
  input  logic                    clk_pixel,
  input  logic                    sys_rst_n,
  sprite_port_scheduler_if.slave  bus
`ifdef SPRITE_SCHED_STATS_EN
  ,
  output logic [7:0]              overrun_count,
  output logic [7:0]              idle_frames
`endif
);

  localparam int               PTR_W     = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_REQ  = PTR_W'(NUM_REQ - 1);
  localparam int               DIV_W     = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(ANIM_DIV - 1);
  localparam logic [FRAME_IDX_W:0] FRAME_MAX = (FRAME_IDX_W+1)'(NUM_FRAMES - 1);

  localparam logic [1:0] ST_IDLE  = IDLE;
  localparam logic [1:0] ST_SCAN  = SCAN;
  localparam logic [1:0] ST_LATCH = LATCH;
  localparam logic [1:0] ST_HOLD  = HOLD;

  logic [1:0]         state_q, state_d;
  logic [PTR_W-1:0]   scan_ptr_q, scan_ptr_d;
  logic [PTR_W-1:0]   scan_cnt_q, scan_cnt_d;
  logic [PTR_W-1:0]   grant_q, grant_d;
  logic [PTR_W-1:0]   last_grant_q, last_grant_d;
  logic [DIV_W-1:0]   div_cnt_q, div_cnt_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  sprite_cmd_t        cmd_q, cmd_d;
  logic               scan_exhausted, latch_fire, anim_step;

  logic [NUM_REQ-1:0][FRAME_IDX_W-1:0] phase, eff_len;
  logic [FRAME_IDX_W-1:0]              use_phase;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_REQ) ? '0 : p + 1'b1;
  endfunction

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_anim
    assign eff_len[i] = (bus.req_frame_len[i] == '0) ? FRAME_IDX_W'(1) : bus.req_frame_len[i];
    anim_phase_counter u_phase (
      .clk_pixel (clk_pixel),
      .sys_rst_n (sys_rst_n),
      .step      (anim_step),
      .eff_len   (eff_len[i]),
      .phase     (phase[i])
    );
  end

  // A phase stranded beyond a freshly shortened length is shown as phase 0.
  assign use_phase = (phase[grant_q] >= eff_len[grant_q]) ? '0 : phase[grant_q];

  always_comb begin
    state_d        = state_q;
    scan_ptr_d     = scan_ptr_q;
    scan_cnt_d     = scan_cnt_q;
    grant_d        = grant_q;
    last_grant_d   = last_grant_q;
    cmd_d          = cmd_q;
    ack_d          = '0;
    scan_exhausted = 1'b0;
    latch_fire     = 1'b0;
    case (state_q)
      ST_IDLE, ST_HOLD: begin
        if (bus.new_frame) begin
          state_d    = ST_SCAN;
          scan_ptr_d = next_ptr(last_grant_q);
          scan_cnt_d = '0;
        end
      end
      ST_SCAN: begin
        if (bus.req_valid[scan_ptr_q]) begin
          grant_d = scan_ptr_q;
          state_d = ST_LATCH;
        end else if (scan_cnt_q == LAST_REQ) begin
          cmd_d          = '0;
          state_d        = ST_HOLD;
          scan_exhausted = 1'b1;
        end else begin
          scan_ptr_d = next_ptr(scan_ptr_q);
          scan_cnt_d = scan_cnt_q + 1'b1;
        end
      end
      ST_LATCH: begin
        cmd_d.valid    = 1'b1;
        cmd_d.x        = bus.req_x[grant_q];
        cmd_d.y        = bus.req_y[grant_q];
        cmd_d.frame    = clamp_frame(bus.req_frame_base[grant_q], use_phase, FRAME_MAX);
        ack_d[grant_q] = 1'b1;
        last_grant_d   = grant_q;
        state_d        = ST_HOLD;
        latch_fire     = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Animation advances after the frame is scheduled, so the frame just latched
  // still uses the phase accumulated by earlier frames.
  always_comb begin
    div_cnt_d = div_cnt_q;
    anim_step = 1'b0;
    if (scan_exhausted || latch_fire) begin
      if (div_cnt_q == DIV_LAST) begin
        div_cnt_d = '0;
        anim_step = 1'b1;
      end else begin
        div_cnt_d = div_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q      <= ST_IDLE;
      scan_ptr_q   <= '0;
      scan_cnt_q   <= '0;
      grant_q      <= '0;
      last_grant_q <= LAST_REQ;
      div_cnt_q    <= '0;
      ack_q        <= '0;
      cmd_q        <= '0;
    end else begin
      state_q      <= state_d;
      scan_ptr_q   <= scan_ptr_d;
      scan_cnt_q   <= scan_cnt_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      div_cnt_q    <= div_cnt_d;
      ack_q        <= ack_d;
      cmd_q        <= cmd_d;
    end
  end

  assign bus.req_ack             = ack_q;
  assign bus.sprite_valid        = cmd_q.valid;
  assign bus.sprite_x            = cmd_q.x;
  assign bus.sprite_y            = cmd_q.y;
  assign bus.sprite_frame_number = cmd_q.frame;
  assign bus.busy                = (state_q == ST_SCAN) || (state_q == ST_LATCH);

`ifdef SPRITE_SCHED_STATS_EN
  logic [7:0] overrun_q, overrun_d, idle_q, idle_d;

  always_comb begin
    overrun_d = overrun_q;
    idle_d    = idle_q;
    if (bus.new_frame && bus.busy && overrun_q != 8'hFF) overrun_d = overrun_q + 1'b1;
    if (scan_exhausted && idle_q != 8'hFF)               idle_d    = idle_q + 1'b1;
  end

  always_ff @(posedge clk_pixel or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      overrun_q <= '0;
      idle_q    <= '0;
    end else begin
      overrun_q <= overrun_d;
      idle_q    <= idle_d;
    end
  end

  assign overrun_count = overrun_q;
  assign idle_frames   = idle_q;
`endif

endmodule

// File: tb/tb_sprite_port_scheduler.sv
// Directed bench for sprite_port_scheduler (NUM_REQ=4, NUM_FRAMES=23, ANIM_DIV=1).
// Stats outputs are checked only when SPRITE_SCHED_STATS_EN is defined.
module tb_sprite_port_scheduler;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [3:0] ack_or;
  int   ack_cycles;
  logic busy_at0;

`ifdef SPRITE_SCHED_STATS_EN
  logic [7:0] overrun_count, idle_frames;
`endif

  sprite_port_scheduler_if #(.NUM_REQ(4)) bus ();

  sprite_port_scheduler #(
    .NUM_REQ    (4),
    .NUM_FRAMES (23),
    .ANIM_DIV   (1)
  ) dut (
    .clk_pixel (clk),
    .sys_rst_n (rst_n),
    .bus       (bus)
`ifdef SPRITE_SCHED_STATS_EN
    ,
    .overrun_count (overrun_count),
    .idle_frames   (idle_frames)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  // One video frame: pulse new_frame, optionally re-pulse 2 cycles later,
  // then watch a bounded window for acks.
  task automatic run_frame(input bit twice);
    ack_or     = '0;
    ack_cycles = 0;
    @(negedge clk);
    bus.new_frame = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.new_frame = (twice && i == 1);
      if (i == 0) busy_at0 = bus.busy;
      if (bus.req_ack != '0) begin
        ack_cycles++;
        ack_or = ack_or | bus.req_ack;
      end
    end
  endtask

  initial begin
    bus.new_frame      = 1'b0;
    bus.req_valid      = '0;
    bus.req_x          = '0;
    bus.req_y          = '0;
    bus.req_frame_base = '0;
    bus.req_frame_len  = '0;

    // Reset values while reset is held
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(bus.sprite_valid), 0);
    check("rst_ack",   32'(bus.req_ack), 0);
    check("rst_busy",  32'(bus.busy), 0);
    check("rst_x",     32'(bus.sprite_x), 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Nobody requesting: three empty frames
    for (int f = 0; f < 3; f++) begin
      run_frame(1'b0);
      check("t1_busy_scan", 32'(busy_at0), 1);
      check("t1_valid",     32'(bus.sprite_valid), 0);
      check("t1_ack",       32'(ack_cycles), 0);
      check("t1_busy_hold", 32'(bus.busy), 0);
    end
`ifdef SPRITE_SCHED_STATS_EN
    check("t1_idle_frames", 32'(idle_frames), 3);
`endif

    // All four requesting: strict round robin
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_x[i]          = 11'(16 * i + 5);
      bus.req_y[i]          = 10'(i + 100);
      bus.req_frame_base[i] = 5'(i);
      bus.req_frame_len[i]  = 5'd1;
    end
    bus.req_valid = 4'b1111;
    for (int f = 0; f < 8; f++) begin
      run_frame(1'b0);
      check("t2_ack_once", 32'(ack_cycles), 1);
      check("t2_ack_id",   32'(ack_or), 32'(1 << (f % 4)));
      check("t2_valid",    32'(bus.sprite_valid), 1);
      check("t2_x",        32'(bus.sprite_x), 32'(16 * (f % 4) + 5));
      check("t2_y",        32'(bus.sprite_y), 32'((f % 4) + 100));
      check("t2_frame",    32'(bus.sprite_frame_number), 32'(f % 4));
      repeat (6) @(negedge clk);
      check("t2_hold_x",   32'(bus.sprite_x), 32'(16 * (f % 4) + 5));
      check("t2_hold_ack", 32'(bus.req_ack), 0);
    end

    // Single requester with 4-frame animation from base 3
    do_reset();
    bus.req_valid         = 4'b0100;
    bus.req_x[2]          = 11'd100;
    bus.req_y[2]          = 10'd200;
    bus.req_frame_base[2] = 5'd3;
    bus.req_frame_len[2]  = 5'd4;
    for (int f = 0; f < 6; f++) begin
      run_frame(1'b0);
      check("t3_ack_id", 32'(ack_or), 32'h4);
      check("t3_x",      32'(bus.sprite_x), 100);
      check("t3_y",      32'(bus.sprite_y), 200);
      check("t3_frame",  32'(bus.sprite_frame_number), 32'(3 + (f % 4)));
    end

    // Clamp at NUM_FRAMES-1, then zero length holds base
    do_reset();
    bus.req_frame_base[2] = 5'd20;
    bus.req_frame_len[2]  = 5'd8;
    for (int f = 0; f < 9; f++) begin
      run_frame(1'b0);
      check("t4_clamp", 32'(bus.sprite_frame_number),
            (f == 8) ? 32'd20 : ((20 + f > 22) ? 32'd22 : 32'(20 + f)));
    end
    bus.req_frame_base[2] = 5'd7;
    bus.req_frame_len[2]  = 5'd0;
    for (int f = 0; f < 3; f++) begin
      run_frame(1'b0);
      check("t4_len0", 32'(bus.sprite_frame_number), 7);
    end

    // Second new_frame while busy is ignored
    do_reset();
    bus.req_valid = 4'b1111;
    run_frame(1'b1);
    check("t5_ack_once", 32'(ack_cycles), 1);
    check("t5_ack_id",   32'(ack_or), 32'h1);
`ifdef SPRITE_SCHED_STATS_EN
    check("t5_overrun",  32'(overrun_count), 1);
`endif
    run_frame(1'b0);
    check("t5_next_id",  32'(ack_or), 32'h2);

    // Reset in the middle of a scan
    do_reset();
    run_frame(1'b0);
    run_frame(1'b0);
    check("t6_pre_id", 32'(ack_or), 32'h2);
    @(negedge clk);
    bus.new_frame = 1'b1;
    @(negedge clk);
    bus.new_frame = 1'b0;
    check("t6_busy_scan", 32'(bus.busy), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", 32'(bus.sprite_valid), 0);
    check("t6_rst_x",     32'(bus.sprite_x), 0);
    check("t6_rst_ack",   32'(bus.req_ack), 0);
    check("t6_rst_busy",  32'(bus.busy), 0);
    @(negedge clk);
    rst_n = 1'b1;
    run_frame(1'b0);
    check("t6_post_id",  32'(ack_or), 32'h1);
    check("t6_post_ack", 32'(ack_cycles), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
